aesl_deadlock_detect_unit: RTL and testbench

AESL_DEADLOCK_DETECT_UNIT -- requirements
Module: aesl_deadlock_detect_unit

---
 rtl/aesl_deadlock_pkg.sv | 51 +++++
 rtl/aesl_deadlock_stall_cnt.sv | 33 +++
 rtl/aesl_deadlock_detect_unit.sv | 128 ++++++++++++
 tb/tb_aesl_deadlock_detect_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Purpose: shared FSM encoding and walk helpers for the deadlock detect unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Helpers work on MAX_PROC-wide vectors. Callers zero-extend their
// PROC_NUM-wide vectors and truncate the result, so PROC_NUM <= MAX_PROC.
package aesl_deadlock_pkg;

  localparam int unsigned MAX_PROC = 32;

  typedef logic [MAX_PROC-1:0] pvec_t;

  localparam logic [1:0] ST_SCAN        = 2'b00;
  localparam logic [1:0] ST_WAIT_ORIGIN = 2'b01;
  localparam logic [1:0] ST_WALK        = 2'b10;

  typedef enum logic [1:0] {
    SCAN        = ST_SCAN,
    WAIT_ORIGIN = ST_WAIT_ORIGIN,
    WALK        = ST_WALK
  } dd_state_t;

  // Position of the highest set bit; 0 for an all-zero vector.
  function automatic int unsigned idx(input pvec_t v);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < MAX_PROC; b++) begin
      if (v[b]) r = b;
    end
    return r;
  endfunction

  // One-hot of the lowest process that is both a dependency in 'row'
  // and currently stalled; zero when no such process exists.
  function automatic pvec_t succ(input pvec_t row, input pvec_t stalled);
    pvec_t hit;
    pvec_t r;
    logic  found;
    hit   = row & stalled;
    r     = '0;
    found = 1'b0;
    for (int unsigned b = 0; b < MAX_PROC; b++) begin
      if (hit[b] && !found) begin
        r[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aesl_deadlock_stall_cnt.sv
// Purpose: per-process saturating stall counter; flags a process as stalled.
// Latency: stalled rises TIMEOUT cycles after blocked is first sampled high.
// Backpressure: none; counts every cycle, clears the cycle blocked is low.
//
// Ports: clock, reset (async active-low), blocked (process waiting),
//        stalled (counter sits at TIMEOUT).
module aesl_deadlock_stall_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic blocked,
  output logic stalled
);

  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!blocked) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stalled = (cnt == SAT);

endmodule

// File: rtl/aesl_deadlock_detect_unit.sv
// Purpose: detects stalled processes in a wait-for cycle and walks the cycle.
// Latency: candidates combinational in SCAN; first walk token 1 cycle after origin.
// Backpressure: none; the report unit paces the walk via origin/token_clear.
//
// Ports: clock, reset (async active-low), proc_blocked[PROC_NUM],
//        proc_dep[PROC_NUM*PROC_NUM] (bit i*PROC_NUM+j: i waits on j),
//        origin[PROC_NUM] (one-hot walk start), token_clear (walk closed),
//        dl_in_vec[PROC_NUM] (candidates or walk token), walk_err (sticky).
module aesl_deadlock_detect_unit
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PROC_NUM-1:0]          proc_blocked,
  input  logic [PROC_NUM*PROC_NUM-1:0] proc_dep,
  input  logic [PROC_NUM-1:0]          origin,
  input  logic                         token_clear,
  output logic [PROC_NUM-1:0]          dl_in_vec,
  output logic                         walk_err
);

  localparam int unsigned SW = $clog2(PROC_NUM + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(PROC_NUM);

  logic [PROC_NUM-1:0] stalled;
  logic [PROC_NUM-1:0] cand;
  logic [PROC_NUM-1:0] token;
  logic [PROC_NUM-1:0] succ_tok;
  logic [PROC_NUM-1:0] succ_org;
  logic [SW-1:0]       step;
  dd_state_t           state;

  // Successor of a one-hot-ish vector: pick the dependency row of its
  // highest set bit. An empty vector has no successor, so a walk that
  // was started from an origin without a stalled successor fails cleanly.
  function automatic logic [PROC_NUM-1:0] succ_of(
    input logic [PROC_NUM-1:0]          v,
    input logic [PROC_NUM*PROC_NUM-1:0] dep,
    input logic [PROC_NUM-1:0]          stl
  );
    logic [PROC_NUM-1:0] row;
    pvec_t               s;
    int unsigned         k;
    row = '0;
    k   = idx(pvec_t'(v));
    for (int unsigned i = 0; i < PROC_NUM; i++) begin
      if (i == k) row = dep[i*PROC_NUM +: PROC_NUM];
    end
    s = succ(pvec_t'(row), pvec_t'(stl));
    return (v == '0) ? '0 : PROC_NUM'(s);
  endfunction

  for (genvar g = 0; g < PROC_NUM; g++) begin : g_cnt
    aesl_deadlock_stall_cnt #(
      .TIMEOUT (TIMEOUT)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .blocked (proc_blocked[g]),
      .stalled (stalled[g])
    );
  end

  // A stalled process is a candidate only if it waits on another stalled one.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < PROC_NUM; i++) begin
      cand[i] = stalled[i] & (|(proc_dep[i*PROC_NUM +: PROC_NUM] & stalled));
    end
  end

  always_comb begin
    succ_tok = succ_of(token, proc_dep, stalled);
    succ_org = succ_of(origin, proc_dep, stalled);
  end

  // SCAN is left for good once a candidate shows up; only reset returns here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      token    <= '0;
      step     <= '0;
      walk_err <= 1'b0;
    end else begin
      unique case (state)
        SCAN: begin
          if (cand != '0) state <= WAIT_ORIGIN;
        end
        WAIT_ORIGIN: begin
          if (origin != '0) begin
            token <= succ_org;
            step  <= '0;
            state <= WALK;
          end
        end
        WALK: begin
          if (token_clear) begin
            token <= '0;
            state <= WAIT_ORIGIN;
          end else if (succ_tok == '0 || step == STEP_MAX) begin
            // Chain broke or ran longer than any real cycle could.
            walk_err <= 1'b1;
            token    <= '0;
            state    <= WAIT_ORIGIN;
          end else begin
            token <= succ_tok;
            step  <= step + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_comb begin
    dl_in_vec = '0;
    unique case (state)
      SCAN:        dl_in_vec = cand;
      WAIT_ORIGIN: dl_in_vec = '0;
      WALK:        dl_in_vec = token;
      default:     dl_in_vec = '0;
    endcase
  end

endmodule

// File: tb/tb_aesl_deadlock_detect_unit.sv
module tb_aesl_deadlock_detect_unit;
  import aesl_deadlock_pkg::*;

  localparam int unsigned P = 2;
  localparam int unsigned T = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [P-1:0]   proc_blocked = '0;
  logic [P*P-1:0] proc_dep = '0;
  logic [P-1:0]   origin = '0;
  logic           token_clear = 1'b0;
  logic [P-1:0]   dl_in_vec;
  logic           walk_err;

  aesl_deadlock_detect_unit #(
    .PROC_NUM (P),
    .TIMEOUT  (T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .proc_blocked (proc_blocked),
    .proc_dep     (proc_dep),
    .origin       (origin),
    .token_clear  (token_clear),
    .dl_in_vec    (dl_in_vec),
    .walk_err     (walk_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [P-1:0] dl;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input logic [P-1:0] dl, input logic err);
    exp_t e;
    e.dl  = dl;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard empty, nothing to compare", tag);
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (dl_in_vec === e.dl) else begin
      n_fail++;
      $error("FAIL %s dl_in_vec got %b expected %b", tag, dl_in_vec, e.dl);
    end
    n_tests++;
    assert (walk_err === e.err) else begin
      n_fail++;
      $error("FAIL %s walk_err got %b expected %b", tag, walk_err, e.err);
    end
  endtask

  task automatic check_state(input dd_state_t st, input string tag);
    dd_state_t s;
    s = dut.state;
    n_tests++;
    assert (s === st) else begin
      n_fail++;
      $error("FAIL %s state got %0d expected %0d", tag, s, st);
    end
  endtask

  // Drive-and-check one cycle: expected outputs for the current cycle, then advance.
  task automatic cyc(input logic [P-1:0] dl, input logic err, input string tag);
    expect_out(dl, err);
    check_out(tag);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    proc_dep = 4'b0110;  // 0 waits on 1, 1 waits on 0

    // Reset state
    #3;
    expect_out(2'b00, 1'b0);
    check_out("reset_out");
    check_state(SCAN, "reset_state");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Only process 0 blocked: no candidate, SCAN held; origin ignored in SCAN
    proc_blocked = 2'b01;
    origin       = 2'b01;
    for (int c = 0; c < 10; c++) cyc(2'b00, 1'b0, "single_blocked");
    origin = 2'b00;
    check_state(SCAN, "single_scan");

    // Interrupted blocking restarts the count
    proc_blocked = 2'b00;
    cyc(2'b00, 1'b0, "clear_cnt");
    proc_blocked = 2'b11;
    cyc(2'b00, 1'b0, "blk1");
    cyc(2'b00, 1'b0, "blk2");
    proc_blocked = 2'b00;
    cyc(2'b00, 1'b0, "blk_drop");
    proc_blocked = 2'b11;
    for (int c = 0; c < 4; c++) cyc(2'b00, 1'b0, "reblock");
    expect_out(2'b11, 1'b0);
    check_out("cand");
    check_state(SCAN, "cand_scan");
    tick();

    // WAIT_ORIGIN: outputs idle, token_clear ignored
    token_clear = 1'b1;
    cyc(2'b00, 1'b0, "wait_hold");
    token_clear = 1'b0;
    check_state(WAIT_ORIGIN, "wait_state");

    // Walk from origin 0, closed by token_clear
    origin = 2'b01;
    cyc(2'b00, 1'b0, "origin1");
    origin = 2'b00;
    cyc(2'b10, 1'b0, "walk_t0");
    token_clear = 1'b1;
    cyc(2'b01, 1'b0, "walk_t1");
    token_clear = 1'b0;
    expect_out(2'b00, 1'b0);
    check_out("after_clear");
    check_state(WAIT_ORIGIN, "after_clear_state");

    // Broken chain: 1 no longer waits on 0
    proc_dep = 4'b0010;
    origin   = 2'b01;
    cyc(2'b00, 1'b0, "origin2");
    origin = 2'b00;
    cyc(2'b10, 1'b0, "walk_nodep");
    expect_out(2'b00, 1'b1);
    check_out("nodep_err");
    check_state(WAIT_ORIGIN, "nodep_state");

    // Reset in the middle of a walk acts without a clock edge
    proc_dep = 4'b0110;
    origin   = 2'b01;
    cyc(2'b00, 1'b1, "origin3");
    origin = 2'b00;
    expect_out(2'b10, 1'b1);
    check_out("walk3");
    #2;
    reset = 1'b0;
    #1;
    expect_out(2'b00, 1'b0);
    check_out("reset_mid");
    check_state(SCAN, "reset_mid_state");
    tick();
    reset = 1'b1;

    // Unclosed walk hits the step limit
    for (int c = 0; c < 4; c++) cyc(2'b00, 1'b0, "reblock2");
    cyc(2'b11, 1'b0, "cand2");
    origin = 2'b01;
    cyc(2'b00, 1'b0, "origin4");
    origin = 2'b00;
    cyc(2'b10, 1'b0, "lim0");
    cyc(2'b01, 1'b0, "lim1");
    cyc(2'b10, 1'b0, "lim2");
    expect_out(2'b00, 1'b1);
    check_out("lim_err");
    check_state(WAIT_ORIGIN, "lim_state");

    // No return to SCAN once stalls clear
    proc_blocked = 2'b00;
    for (int c = 0; c < 3; c++) cyc(2'b00, 1'b1, "idle");
    check_state(WAIT_ORIGIN, "no_return_scan");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
